// File: rtl/fas_pkg.sv
// Shared types and constants for the FAS analysis chain.
// Bin layout, magnitude type and scan FSM states.
package fas_pkg;

    localparam int FAS_NBINS = 16;
    localparam int FAS_DW    = 16;
    localparam int FAS_LANES = 2;
    localparam int FAS_IW    = $clog2(FAS_NBINS);
    localparam int FAS_SW    = $clog2(FAS_NBINS / FAS_LANES);

    typedef struct packed {
        logic signed [FAS_DW-1:0] re;
        logic signed [FAS_DW-1:0] im;
    } cplx_t;

    typedef logic [31:0] mag2_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } state_t;

endpackage

// File: rtl/fas_mag2.sv
// Squared magnitude of one complex bin.
// re*re + im*im; each square fits 31 bits, the sum fits 32 unsigned.
module fas_mag2
    import fas_pkg::*;
(
    input  cplx_t bin,
    output mag2_t mag2
);

    logic signed [31:0] re_x;
    logic signed [31:0] im_x;
    logic signed [31:0] re_sq;
    logic signed [31:0] im_sq;

    assign re_x  = 32'(bin.re);
    assign im_x  = 32'(bin.im);
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;
    assign mag2  = mag2_t'(re_sq) + mag2_t'(im_sq);

endmodule

// File: rtl/fas_spectrum_peak.sv
// Peak-bin finder: captures a 16-bin FFT frame and scans two bins
// per cycle for the largest squared magnitude, lowest index on ties.
module fas_spectrum_peak
    import fas_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fft_valid,
    input  logic [31:0] fft_d0,
    input  logic [31:0] fft_d1,
    input  logic [31:0] fft_d2,
    input  logic [31:0] fft_d3,
    input  logic [31:0] fft_d4,
    input  logic [31:0] fft_d5,
    input  logic [31:0] fft_d6,
    input  logic [31:0] fft_d7,
    input  logic [31:0] fft_d8,
    input  logic [31:0] fft_d9,
    input  logic [31:0] fft_d10,
    input  logic [31:0] fft_d11,
    input  logic [31:0] fft_d12,
    input  logic [31:0] fft_d13,
    input  logic [31:0] fft_d14,
    input  logic [31:0] fft_d15,
    output logic        done,
    output logic [3:0]  freq,
    output logic        overrun
);

    state_t              state;
    state_t              state_nx;
    logic [FAS_SW-1:0]   idx;
    mag2_t               max_q;
    logic [FAS_IW-1:0]   best_q;
    mag2_t               run_max;
    logic [FAS_IW-1:0]   run_best;
    logic                capture;

    cplx_t in_frame [FAS_NBINS];
    cplx_t bank     [FAS_NBINS];
    cplx_t lane_bin [FAS_LANES];
    mag2_t lane_mag [FAS_LANES];

    assign in_frame[0]  = cplx_t'(fft_d0);
    assign in_frame[1]  = cplx_t'(fft_d1);
    assign in_frame[2]  = cplx_t'(fft_d2);
    assign in_frame[3]  = cplx_t'(fft_d3);
    assign in_frame[4]  = cplx_t'(fft_d4);
    assign in_frame[5]  = cplx_t'(fft_d5);
    assign in_frame[6]  = cplx_t'(fft_d6);
    assign in_frame[7]  = cplx_t'(fft_d7);
    assign in_frame[8]  = cplx_t'(fft_d8);
    assign in_frame[9]  = cplx_t'(fft_d9);
    assign in_frame[10] = cplx_t'(fft_d10);
    assign in_frame[11] = cplx_t'(fft_d11);
    assign in_frame[12] = cplx_t'(fft_d12);
    assign in_frame[13] = cplx_t'(fft_d13);
    assign in_frame[14] = cplx_t'(fft_d14);
    assign in_frame[15] = cplx_t'(fft_d15);

    // A strobe is only taken when no scan is in flight.
    assign capture = fft_valid && (state != SCAN);

    for (genvar l = 0; l < FAS_LANES; l++) begin : g_lane
        assign lane_bin[l] = bank[{idx, 1'(l)}];
        fas_mag2 u_mag2 (
            .bin  (lane_bin[l]),
            .mag2 (lane_mag[l])
        );
    end

    // Chain the lanes in index order; strict > keeps the lower bin on ties.
    always_comb begin
        run_max  = max_q;
        run_best = best_q;
        for (int l = 0; l < FAS_LANES; l++) begin
            if (lane_mag[l] > run_max) begin
                run_max  = lane_mag[l];
                run_best = {idx, 1'(l)};
            end
        end
    end

    // Next-state logic for IDLE -> SCAN (8 cycles) -> REPORT.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (fft_valid) state_nx = SCAN;
            SCAN:    if (&idx) state_nx = REPORT;
            REPORT:  state_nx = fft_valid ? SCAN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, scan counter, running best and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            max_q   <= '0;
            best_q  <= '0;
            done    <= 1'b0;
            freq    <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == REPORT);
            if (state == REPORT) freq <= best_q;
            if (fft_valid && state == SCAN) overrun <= 1'b1;
            if (capture) begin
                idx    <= '0;
                max_q  <= '0;
                best_q <= '0;
            end else if (state == SCAN) begin
                idx    <= idx + 1'b1;
                max_q  <= run_max;
                best_q <= run_best;
            end
        end
    end

    // Frame bank holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < FAS_NBINS; k++) bank[k] <= in_frame[k];
        end
    end

endmodule

// File: tb/tb_fas_spectrum_peak.sv
// Bench for fas_spectrum_peak: directed frames plus random traffic,
// compared every cycle against a frame-level timing/peak model.
module tb_fas_spectrum_peak;

    typedef logic [31:0] frame_t [16];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fft_valid = 1'b0;
    logic [31:0] d [16];
    logic        done;
    logic [3:0]  freq;
    logic        overrun;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    int   cyc = 0;
    int   last_cap = 0;
    bit   have_cap = 1'b0;
    int   at_q [$];
    int   fr_q [$];
    logic exp_done = 1'b0;
    logic [3:0] exp_freq = '0;
    logic exp_ovr = 1'b0;
    int   seen [$];

    fas_spectrum_peak dut (
        .clk       (clk),
        .rst       (rst),
        .fft_valid (fft_valid),
        .fft_d0    (d[0]),
        .fft_d1    (d[1]),
        .fft_d2    (d[2]),
        .fft_d3    (d[3]),
        .fft_d4    (d[4]),
        .fft_d5    (d[5]),
        .fft_d6    (d[6]),
        .fft_d7    (d[7]),
        .fft_d8    (d[8]),
        .fft_d9    (d[9]),
        .fft_d10   (d[10]),
        .fft_d11   (d[11]),
        .fft_d12   (d[12]),
        .fft_d13   (d[13]),
        .fft_d14   (d[14]),
        .fft_d15   (d[15]),
        .done      (done),
        .freq      (freq),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Index of the largest re^2+im^2, first (lowest) index wins ties.
    function automatic int peak(frame_t f);
        longint best_m = 0;
        int     best_i = 0;
        for (int k = 0; k < 16; k++) begin
            longint re = longint'($signed(f[k][31:16]));
            longint im = longint'($signed(f[k][15:0]));
            longint m  = re * re + im * im;
            if (m > best_m) begin
                best_m = m;
                best_i = k;
            end
        end
        return best_i;
    endfunction

    // Frame-level model: accepted strobes report 9 edges later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0;
            have_cap = 1'b0;
            at_q.delete();
            fr_q.delete();
            exp_done = 1'b0;
            exp_freq = '0;
            exp_ovr = 1'b0;
        end else begin
            cyc++;
            exp_done = 1'b0;
            if (at_q.size() > 0 && at_q[0] == cyc) begin
                exp_done = 1'b1;
                exp_freq = 4'(fr_q[0]);
                void'(at_q.pop_front());
                void'(fr_q.pop_front());
            end
            if (fft_valid) begin
                if (!have_cap || cyc >= last_cap + 9) begin
                    have_cap = 1'b1;
                    last_cap = cyc;
                    at_q.push_back(cyc + 9);
                    fr_q.push_back(peak(d));
                end else begin
                    exp_ovr = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (done !== exp_done) begin
                miscompares++;
                $display("FAIL done cyc=%0d got %b want %b", cyc, done, exp_done);
            end
            vectors++;
            if (freq !== exp_freq) begin
                miscompares++;
                $display("FAIL freq cyc=%0d got %0d want %0d", cyc, freq, exp_freq);
            end
            vectors++;
            if (overrun !== exp_ovr) begin
                miscompares++;
                $display("FAIL overrun cyc=%0d got %b want %b", cyc, overrun, exp_ovr);
            end
        end
    end

    // Log every reported peak for the directed checks.
    always @(negedge clk) begin
        if (done === 1'b1) seen.push_back(int'(freq));
    end

    task automatic check_int(string nm, int got, int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic check_list(string nm, int n, int a, int b);
        check_int({nm, "_count"}, seen.size(), n);
        if (n > 0 && seen.size() > 0) check_int({nm, "_first"}, seen[0], a);
        if (n > 1 && seen.size() > 1) check_int({nm, "_second"}, seen[1], b);
        seen.delete();
    endtask

    task automatic drive(frame_t f, int hold);
        @(negedge clk);
        #1;
        d = f;
        fft_valid = 1'b1;
        repeat (hold) @(negedge clk);
        #1;
        fft_valid = 1'b0;
    endtask

    function automatic frame_t zero_frame();
        frame_t f;
        for (int k = 0; k < 16; k++) f[k] = '0;
        return f;
    endfunction

    function automatic frame_t one_peak(int k, logic [31:0] v);
        frame_t f = zero_frame();
        f[k] = v;
        return f;
    endfunction

    function automatic frame_t rand_frame(int mode);
        frame_t f;
        for (int k = 0; k < 16; k++) begin
            if (mode == 0) begin
                f[k] = $urandom;
            end else begin
                logic [15:0] re = 16'($urandom_range(0, 4)) - 16'd2;
                logic [15:0] im = 16'($urandom_range(0, 4)) - 16'd2;
                f[k] = {re, im};
            end
        end
        return f;
    endfunction

    initial begin
        frame_t fa;
        frame_t fb;
        for (int k = 0; k < 16; k++) d[k] = '0;
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        fa = one_peak(5, {16'h0300, 16'h0400});
        check_int("pin_single", peak(fa), 5);
        drive(fa, 1);
        repeat (12) @(negedge clk);
        check_list("single", 1, 5, 0);
        check_int("single_ovr", int'(overrun), 0);

        fa = one_peak(1, {16'h0100, 16'h0000});
        fa[15] = {16'h0100, 16'h0000};
        check_int("pin_tie", peak(fa), 1);
        drive(fa, 1);
        repeat (12) @(negedge clk);
        check_list("tie", 1, 1, 0);
        fa[15] = {16'h0101, 16'h0000};
        drive(fa, 1);
        repeat (12) @(negedge clk);
        check_list("tie_swap", 1, 15, 0);

        fa = one_peak(9, {16'h8000, 16'h8000});
        fa[3] = {16'h7FFF, 16'h7FFF};
        check_int("pin_ext", peak(fa), 9);
        drive(fa, 1);
        repeat (12) @(negedge clk);
        check_list("extreme", 1, 9, 0);
        drive(zero_frame(), 1);
        repeat (12) @(negedge clk);
        check_list("zero", 1, 0, 0);

        fa = one_peak(2, {16'h0200, 16'hFE00});
        fb = one_peak(12, {16'hF000, 16'h0010});
        drive(fa, 1);
        repeat (7) @(negedge clk);
        drive(fb, 1);
        repeat (12) @(negedge clk);
        check_list("b2b9", 2, 2, 12);
        check_int("b2b9_ovr", int'(overrun), 0);
        drive(fa, 1);
        repeat (14) @(negedge clk);
        drive(fb, 1);
        repeat (12) @(negedge clk);
        check_list("b2b16", 2, 2, 12);
        check_int("b2b16_ovr", int'(overrun), 0);

        fa = one_peak(4, {16'h0040, 16'h0000});
        fb = one_peak(7, {16'h0400, 16'h0000});
        drive(fa, 1);
        repeat (2) @(negedge clk);
        drive(fb, 1);
        repeat (12) @(negedge clk);
        check_list("ovr", 1, 4, 0);
        check_int("ovr_set", int'(overrun), 1);
        drive(one_peak(10, {16'h0001, 16'h0001}), 1);
        repeat (12) @(negedge clk);
        check_list("ovr_clean", 1, 10, 0);
        check_int("ovr_sticky", int'(overrun), 1);

        drive(one_peak(6, {16'h0500, 16'h0500}), 1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_int("rst_done", int'(done), 0);
        check_int("rst_freq", int'(freq), 0);
        check_int("rst_ovr", int'(overrun), 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (14) @(negedge clk);
        check_list("rst_nodone", 0, 0, 0);
        drive(one_peak(11, {16'hFF00, 16'h0000}), 1);
        repeat (12) @(negedge clk);
        check_list("rst_after", 1, 11, 0);

        for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 99);
            int hold = (r < 8) ? $urandom_range(2, 4) : 1;
            int gap = (r < 20) ? $urandom_range(0, 8) : $urandom_range(7, 16);
            if (r < 3) begin
                @(negedge clk);
                #1 rst = 1'b1;
                @(negedge clk);
                #1 rst = 1'b0;
            end
            drive(rand_frame(r % 2), hold);
            repeat (gap) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        seen.delete();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fas_spectrum_peak.md
Name: fas_spectrum_peak

Overview:
- Analysis stage of the FAS chain. Sits directly downstream of the 16-point FFT and consumes each 16-bin frame it produces.
- For every frame, finds the bin with the largest squared magnitude and reports its index on freq with a one-cycle done pulse.
- Scans 2 bins per cycle, so a frame is fully processed before the next FFT frame arrives (FFT frames are at least 16 cycles apart).

Parameters:
- NBINS, 16, FFT bins per frame. Fixed; the freq width is log2(NBINS).
- DW, 16, width of each real/imag component (signed 8.8, two's complement).
- LANES, 2, bins evaluated per scan cycle. NBINS/LANES = 8 scan cycles.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- fft_valid  in  1  one-cycle strobe: fft_d0..fft_d15 hold a complete frame
- fft_d0..fft_d15  in  32 each  bin k = {real[31:16], imag[15:0]}, signed 8.8
- done  out  1  one-cycle pulse: freq holds the result for the frame just scanned
- freq  out  4  index of the peak bin; held until the next done
- overrun  out  1  sticky flag: a frame arrived while busy; cleared only by rst

Behaviour:
- Reset (async, active-high): state=IDLE, done=0, freq=0, overrun=0, index counter=0, running max=0. The frame bank is not reset.
- States: IDLE, SCAN, REPORT.
- IDLE:
  - fft_valid=1 -> latch all 16 words into the frame bank, clear running max and best index, set idx=0, go to SCAN.
- SCAN (8 cycles, idx = 0..7):
  - Each cycle evaluate bins 2*idx and 2*idx+1.
  - mag2 = re*re + im*im, signed products summed as 32-bit unsigned. Max is 2^31 (re=im=-32768); no overflow.
  - Comparison order: lane 0 is compared against the running max first, then lane 1 against the updated max.
  - The running max updates only on strictly greater. Ties keep the lower index, so mirrored bins 1/15 report 1.
  - All-zero frame -> best index stays 0.
  - After idx=7 -> REPORT.
- REPORT (1 cycle):
  - done=1 and freq=best index, both registered outputs.
  - fft_valid=1 in this cycle is accepted exactly as in IDLE (capture, go to SCAN). Otherwise go to IDLE.
- done is 0 in every cycle other than REPORT.
- Latency: with fft_valid sampled at edge T, done is high in the cycle after edge T+9. Minimum frame spacing is 9 cycles.
- fft_valid during SCAN:
  - The frame is dropped; the bank is not modified and the scan in progress completes unaffected.
  - overrun is set to 1 and stays 1 until rst.
- fft_valid held high across multiple cycles: each cycle counts as a strobe. Capture happens in IDLE/REPORT; every SCAN-cycle strobe sets overrun.
- Reset mid-SCAN: the scan aborts, no done is produced, freq returns to 0.
- freq keeps its value through IDLE and SCAN and changes only in a REPORT cycle.

Decomposition:
- Shared package fas_pkg holds:
  - FAS_NBINS=16, FAS_DW=16, FAS_LANES=2
  - typedef cplx_t (packed struct: re, im, signed DW each)
  - typedef mag2_t (32-bit unsigned)
  - state enum {IDLE, SCAN, REPORT}
- Sub-module fas_mag2: combinational. Takes one cplx_t, returns mag2_t. Instantiated LANES times.
- Comparator, counter and frame bank live in fas_spectrum_peak.

Test Plan:
- Single peak: bin5={0x0300,0x0400}, all others 0, fft_valid at edge T -> done=1 for exactly one cycle after edge T+9, freq=5, overrun=0.
- Mirrored tie: bins 1 and 15 = {0x0100,0x0000}, all others 0 -> freq=1. Swap bin 15 to {0x0101,0} -> freq=15.
- Sign and width extremes:
  - bin9={0x8000,0x8000} (mag2=2^31), bin3={0x7FFF,0x7FFF} -> freq=9.
  - All-zero frame -> freq=0, done still pulses.
- Back-to-back frames:
  - Frame A (peak bin 2), then frame B (peak bin 12) with fft_valid in A's REPORT cycle (spacing 9) -> dones 9 cycles apart, freq=2 then 12, overrun=0.
  - Same test with 16-cycle spacing -> same results.
- Overrun: frame A (peak bin 4), then frame B (peak bin 7) 4 cycles later -> overrun=1 from the next cycle, single done with freq=4, overrun still 1 after a later clean frame.
- Reset mid-scan: frame with peak bin 6, assert rst 3 cycles after capture -> done, freq and overrun immediately 0. No done appears. The next frame after rst deasserts reports correctly.
